// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice,
// processing one nibble per clock (LSB first) with valid/ready handshakes on both sides.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_op_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0] w_nib_a [NIB];
  logic [3:0] w_nib_b [NIB];
  logic [3:0] w_sa;
  logic [3:0] w_sb;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_cc;
  logic [3:0] w_s;
  logic       w_accept;
  logic       w_last;

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign w_nib_a[gi] = r_op_a[4*gi +: 4];
      assign w_nib_b[gi] = r_op_b[4*gi +: 4];
    end
  endgenerate

  assign w_sa = w_nib_a[r_idx];
  assign w_sb = w_nib_b[r_idx];
  assign w_g  = w_sa & w_sb;
  assign w_p  = w_sa ^ w_sb;

  // w_cc[0] is the carry into the slice; w_cc[k+1] is the carry out of bit k.
  assign w_cc[0] = r_carry;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cla
      assign w_cc[gi+1] = w_g[gi] | (w_p[gi] & w_cc[gi]);
      assign w_s[gi]    = w_p[gi] ^ w_cc[gi];
    end
  endgenerate

  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign w_last   = (r_idx == IDXW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_in_valid) w_state_next = S_RUN;
      S_RUN:  if (w_last) w_state_next = S_DONE;
      S_DONE: if (i_out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == S_IDLE);
    o_out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      r_op_a  <= i_a;
      r_op_b  <= i_op_sub ? ~i_b : i_b;
      r_carry <= i_op_sub;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      for (int k = 0; k < NIB; k++) begin
        if (r_idx == IDXW'(k)) r_sum[4*k +: 4] <= w_s;
      end
      r_carry <= w_cc[4];
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_cc[4];
        r_ovf  <= w_cc[4] ^ w_cc[3];
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit carry-lookahead slice. The slice uses generate g=a&b, propagate p=a^b, and per-bit carries c[i]=g[i]|(p[i]&c[i-1]). The block processes one nibble per clock, least-significant first, holding the inter-nibble carry in a register. It sits between an operand source and a result sink, with valid/ready handshakes on both sides. It lets wide arithmetic reuse the narrow adder datapath instead of instantiating a wide adder.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4. NIB = WIDTH/4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op_sub  in  1  0: A+B; 1: A−B, computed as A + ~B + 1.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH−1. For subtract, 1 means no borrow.
- ovf  out  1  signed overflow: c[3]^c[2] of the top nibble.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a into opA; latch (op_sub ? ~b : b) into opB; carry register ← op_sub; nibble index ← 0; go to RUN.
- **RUN**
  - in_ready=0, out_valid=0.
  - Each cycle, slice inputs are opA[4i+3:4i], opB[4i+3:4i] and the carry register, with i = index.
  - At the clock edge:
    - sum[4i+3:4i] ← slice s.
    - carry ← slice c[3].
    - index ← index+1.
  - When index==NIB−1, on that edge also: cout ← c[3]; ovf ← c[3]^c[2]; go to DONE.
- **DONE**
  - out_valid=1; in_ready=0.
  - On out_ready: go to IDLE. out_valid drops next cycle.
- Operands are sampled only at acceptance. Later changes on a, b and op_sub have no effect.
- in_valid while in RUN or DONE is ignored; the source must hold the request.
- sum, cout and ovf stay stable from out_valid rise until the output handshake. They then hold their last value until the nibbles of the next operation overwrite them.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Index register width is max(1, clog2(NIB)).
- WIDTH=4 (NIB=1): RUN lasts exactly one cycle.

## Timing
- Reset (async assert, any state):
  - state=IDLE.
  - in_ready=1 immediately.
  - out_valid=0, sum=0, cout=0, ovf=0, carry=0, index=0.
  - Any in-flight operation is discarded and no result is emitted.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- Latency: acceptance at edge E0. out_valid is high in the cycle after edge E0+NIB (4 cycles after acceptance for WIDTH=16).
- Throughput: acceptance and result delivery never overlap. The minimum spacing between acceptances is NIB+2 cycles when out_ready is held high.
- Output handshake in DONE: the block returns to IDLE on that edge and can accept new operands on the following edge.
- Deassertion of rst_n needs no special handling beyond standard reset-release timing. The first acceptance is possible on the first edge after release.

## Test plan
- WIDTH=16, 0x1234+0x4321, op_sub=0:
  - sum=0x5555, cout=0, ovf=0.
  - out_valid high 4 cycles after acceptance; in_ready low throughout.
- 0xFFFF+0x0001 (carry ripples through every nibble via the carry register): sum=0x0000, cout=1, ovf=0.
- 0x7FFF+0x0001: sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005−0x0007 → sum=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure and operand stability:
  - Hold out_ready=0 for 5 cycles in DONE and drive in_valid with new operands. Required: sum/cout/ovf stable, in_ready=0, new request not taken.
  - Change a/b during RUN. Required: result unaffected.
- Reset mid-RUN:
  - Assert rst_n=0 at index 2. Required: immediately out_valid=0, in_ready=1, sum=0.
  - After release, 0x0F0F+0x00F1 gives sum=0x1000, cout=0.
